// File: rtl/demux16_write_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demux16_write_sched
// Purpose  : Round-robin write scheduler for the 16-way word demultiplexer.
//            NREQ requesters offer (destination, data) pairs. One request at
//            a time is accepted into a single holding stage. The stage drives
//            the demux select and the demux input word. A one-hot load strobe
//            fires toward the held destination whenever that destination is
//            not busy.
// Ports    : clk        - clock; all state updates on the rising edge
//            rst_n      - synchronous active-low reset
//            req_valid  - per-requester pending write
//            req_dest   - per-requester destination index, 4 bits each
//            req_data   - per-requester data word, WIDTH bits each
//            req_ready  - one-hot grant (or zero), combinational
//            dest_busy  - per-destination "cannot load this cycle"
//            sel        - held destination index (demux select)
//            out_data   - held data word (demux input)
//            load_en    - one-hot load strobe toward sel, else zero
//            xfer_count - number of completed loads, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module demux16_write_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*4-1:0]       req_dest,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic [15:0]             dest_busy,
    output logic [3:0]              sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [15:0]             load_en,
    output logic [15:0]             xfer_count
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_ptr_w:0]   c_nreq      = (c_ptr_w+1)'(NREQ);
    localparam logic [c_ptr_w-1:0] c_last_req  = c_ptr_w'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [3:0]          r_sel;
    logic [WIDTH-1:0]    r_data;
    logic [15:0]         r_count;
    logic [c_ptr_w-1:0]  r_rr_ptr;

    logic                w_complete;
    logic                w_can_accept;
    logic                w_grant;
    logic [c_ptr_w-1:0]  w_gidx;
    logic [3:0]          w_gdest;
    logic [WIDTH-1:0]    w_gdata;
    logic [c_ptr_w-1:0]  w_cand [NREQ];
    logic [3:0]          w_cand_dest [NREQ];
    logic [WIDTH-1:0]    w_cand_data [NREQ];

    // Held request leaves the stage this cycle. Reset masks it so that a
    // held transfer is dropped without ever strobing its destination.
    assign w_complete   = rst_n & (r_state == ST_FULL) & ~dest_busy[r_sel];
    assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | w_complete);

    // Search order: candidate k is requester (rr_ptr + k) mod NREQ. Both
    // terms are below NREQ, so one conditional subtract performs the wrap.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [c_ptr_w:0] w_sum;
            assign w_sum           = {1'b0, r_rr_ptr} + (c_ptr_w+1)'(gi);
            assign w_cand[gi]      = c_ptr_w'((w_sum >= c_nreq) ? (w_sum - c_nreq) : w_sum);
            assign w_cand_dest[gi] = req_dest[4*gi +: 4];
            assign w_cand_data[gi] = req_data[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // First valid candidate in round-robin order wins.
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        w_gdest = '0;
        w_gdata = '0;
        if (w_can_accept) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_grant && req_valid[w_cand[k]]) begin
                    w_grant = 1'b1;
                    w_gidx  = w_cand[k];
                    w_gdest = w_cand_dest[w_cand[k]];
                    w_gdata = w_cand_data[w_cand[k]];
                end
            end
        end
    end

    assign req_ready  = w_grant ? (NREQ'(1) << w_gidx) : '0;
    assign load_en    = w_complete ? (16'd1 << r_sel) : 16'd0;
    assign sel        = r_sel;
    assign out_data   = r_data;
    assign xfer_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_sel    <= '0;
            r_data   <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_complete) begin
                r_count <= r_count + 16'd1;
            end
            if (w_grant) begin
                r_state  <= ST_FULL;
                r_sel    <= w_gdest;
                r_data   <= w_gdata;
                r_rr_ptr <= (w_gidx == c_last_req) ? '0 : (w_gidx + 1'b1);
            end else if (w_complete) begin
                r_state  <= ST_EMPTY;
            end
        end
    end

endmodule
`default_nettype wire
